// File: rtl/voice_allocator.sv
// ============================================================================
// voice_allocator: assigns song-reader notes to three voices, steals the
// shortest-remaining voice when all are busy, and paces the song in beats.
// Revision: 1.0
// ============================================================================
`default_nettype none

module voice_allocator #(
  parameter int NOTE_WIDTH = 6,
  parameter int DUR_WIDTH  = 6
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    play_i,
  input  logic                    beat_i,
  input  logic                    new_note_i,
  input  logic [NOTE_WIDTH-1:0]   note_i,
  input  logic [DUR_WIDTH-1:0]    duration_i,
  input  logic                    advance_i,
  output logic [2:0]              load_o,
  output logic [3*NOTE_WIDTH-1:0] voice_note_o,
  output logic [2:0]              voice_active_o,
  output logic [2:0]              voice_done_o,
  output logic                    note_done_o,
  output logic                    stolen_o,
  output logic                    protocol_err_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]                 state_q, state_d;
  logic [DUR_WIDTH-1:0]       tcnt_q, tcnt_d;
  logic [2:0]                 active_q, active_d;
  logic [2:0][NOTE_WIDTH-1:0] vnote_q, vnote_d;
  logic [2:0][DUR_WIDTH-1:0]  vcnt_q, vcnt_d;
  logic [2:0]                 load_q, load_d;
  logic [2:0]                 done_q, done_d;
  logic                       stolen_q, stolen_d;
  logic                       perr_q, perr_d;

  logic       tick;
  logic       accept;
  logic       alloc;
  logic [2:0] expire;
  logic [2:0] free;
  logic [2:0] sel;

  assign tick   = beat_i && play_i;
  assign accept = new_note_i && (state_q == ST_IDLE);
  assign alloc  = accept && (note_i != '0) && (duration_i != '0);

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      expire[i] = tick && active_q[i] && (vcnt_q[i] == DUR_WIDTH'(1));
      free[i]   = !active_q[i] || expire[i];
    end
  end

  // Free voices win by lowest index; otherwise steal the smallest remaining count.
  always_comb begin
    sel = 3'b000;
    if (free[0])
      sel = 3'b001;
    else if (free[1])
      sel = 3'b010;
    else if (free[2])
      sel = 3'b100;
    else if ((vcnt_q[0] <= vcnt_q[1]) && (vcnt_q[0] <= vcnt_q[2]))
      sel = 3'b001;
    else if (vcnt_q[1] <= vcnt_q[2])
      sel = 3'b010;
    else
      sel = 3'b100;
  end

  always_comb begin
    active_d = active_q;
    vnote_d  = vnote_q;
    vcnt_d   = vcnt_q;
    done_d   = 3'b000;
    load_d   = alloc ? sel : 3'b000;
    stolen_d = alloc && !(|free);
    for (int i = 0; i < 3; i++) begin
      if (load_d[i]) begin
        active_d[i] = 1'b1;
        vnote_d[i]  = note_i;
        vcnt_d[i]   = duration_i;
      end else if (expire[i]) begin
        active_d[i] = 1'b0;
        vnote_d[i]  = '0;
        vcnt_d[i]   = '0;
        done_d[i]   = 1'b1;
      end else if (tick && active_q[i]) begin
        vcnt_d[i]   = vcnt_q[i] - DUR_WIDTH'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    perr_d  = perr_q || (new_note_i && (state_q != ST_IDLE));
    case (state_q)
      ST_IDLE: begin
        if (new_note_i) begin
          if (advance_i && (duration_i != '0)) begin
            state_d = ST_WAIT;
            tcnt_d  = duration_i;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_WAIT: begin
        if (tick) begin
          if (tcnt_q == DUR_WIDTH'(1)) begin
            state_d = ST_DONE;
            tcnt_d  = '0;
          end else begin
            tcnt_d  = tcnt_q - DUR_WIDTH'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      tcnt_q   <= '0;
      active_q <= '0;
      vnote_q  <= '0;
      vcnt_q   <= '0;
      load_q   <= '0;
      done_q   <= '0;
      stolen_q <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tcnt_q   <= tcnt_d;
      active_q <= active_d;
      vnote_q  <= vnote_d;
      vcnt_q   <= vcnt_d;
      load_q   <= load_d;
      done_q   <= done_d;
      stolen_q <= stolen_d;
      perr_q   <= perr_d;
    end
  end

  assign load_o         = load_q;
  assign voice_note_o   = vnote_q;
  assign voice_active_o = active_q;
  assign voice_done_o   = done_q;
  assign note_done_o    = (state_q == ST_DONE);
  assign stolen_o       = stolen_q;
  assign protocol_err_o = perr_q;

endmodule

`default_nettype wire

// File: tb/tb_voice_allocator.sv
// ============================================================================
// tb_voice_allocator: directed-vector bench for voice_allocator.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_voice_allocator;

  logic        clk;
  logic        reset;
  logic        play;
  logic        beat;
  logic        new_note;
  logic [5:0]  note;
  logic [5:0]  duration;
  logic        advance;
  logic [2:0]  load;
  logic [17:0] voice_note;
  logic [2:0]  voice_active;
  logic [2:0]  voice_done;
  logic        note_done;
  logic        stolen;
  logic        protocol_err;

  int n_checks = 0;
  int n_errs   = 0;
  int nd_seen;

  voice_allocator #(.NOTE_WIDTH(6), .DUR_WIDTH(6)) u_dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .play_i         (play),
    .beat_i         (beat),
    .new_note_i     (new_note),
    .note_i         (note),
    .duration_i     (duration),
    .advance_i      (advance),
    .load_o         (load),
    .voice_note_o   (voice_note),
    .voice_active_o (voice_active),
    .voice_done_o   (voice_done),
    .note_done_o    (note_done),
    .stolen_o       (stolen),
    .protocol_err_o (protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [5:0] n, input logic [5:0] d, input logic a, input logic b);
    new_note = 1'b1;
    note     = n;
    duration = d;
    advance  = a;
    beat     = b;
    step();
    new_note = 1'b0;
    beat     = 1'b0;
  endtask

  task automatic beat_after(input int gap);
    repeat (gap) step();
    beat = 1'b1;
    step();
    beat = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; play = 1'b1; beat = 1'b0; new_note = 1'b0;
    note = '0; duration = '0; advance = 1'b0;
    do_reset();
    check("rst_load",   32'(load), 32'h0);
    check("rst_vnote",  32'(voice_note), 32'h0);
    check("rst_active", 32'(voice_active), 32'h0);
    check("rst_vdone",  32'(voice_done), 32'h0);
    check("rst_ndone",  32'(note_done), 32'h0);
    check("rst_stolen", 32'(stolen), 32'h0);
    check("rst_perr",   32'(protocol_err), 32'h0);

    // Single timed note
    send(6'd20, 6'd3, 1'b1, 1'b0);
    check("single_load",  32'(load), 32'h1);
    check("single_vnote", 32'(voice_note[5:0]), 32'd20);
    check("single_nd0",   32'(note_done), 32'h0);
    beat_after(9);
    check("single_b1_nd", 32'(note_done), 32'h0);
    beat_after(9);
    check("single_b2_nd", 32'(note_done), 32'h0);
    beat_after(9);
    check("single_b3_nd",    32'(note_done), 32'h1);
    check("single_b3_vdone", 32'(voice_done), 32'h1);
    check("single_b3_act",   32'(voice_active), 32'h0);
    step();
    check("single_nd_pulse", 32'(note_done), 32'h0);
    check("single_vd_pulse", 32'(voice_done), 32'h0);

    // Chord 10, 14 then timed 17
    send(6'd10, 6'd5, 1'b0, 1'b0);
    check("chord0_load", 32'(load), 32'h1);
    check("chord0_nd",   32'(note_done), 32'h1);
    step();
    send(6'd14, 6'd5, 1'b0, 1'b0);
    check("chord1_load", 32'(load), 32'h2);
    check("chord1_nd",   32'(note_done), 32'h1);
    step();
    send(6'd17, 6'd2, 1'b1, 1'b0);
    check("chord2_load",  32'(load), 32'h4);
    check("chord2_act",   32'(voice_active), 32'h7);
    check("chord2_vnote", 32'(voice_note), 32'({6'd17, 6'd14, 6'd10}));
    check("chord2_nd",    32'(note_done), 32'h0);
    beat_after(3);
    beat_after(3);
    check("chord_end_nd",    32'(note_done), 32'h1);
    check("chord_end_vdone", 32'(voice_done), 32'h4);
    check("chord_end_act",   32'(voice_active), 32'h3);

    // Steal: counts 5,2,2 -> voice 1
    do_reset();
    send(6'd1, 6'd5, 1'b0, 1'b0); step();
    send(6'd2, 6'd2, 1'b0, 1'b0); step();
    send(6'd3, 6'd2, 1'b0, 1'b0); step();
    send(6'd30, 6'd4, 1'b0, 1'b0);
    check("steal_load",   32'(load), 32'h2);
    check("steal_stolen", 32'(stolen), 32'h1);
    check("steal_vdone",  32'(voice_done), 32'h0);
    check("steal_vnote",  32'(voice_note), 32'({6'd3, 6'd30, 6'd1}));
    step();
    check("steal_pulse", 32'(stolen), 32'h0);

    // Same-cycle expiry: voice 0 at count 1 reused
    do_reset();
    send(6'd5, 6'd1, 1'b0, 1'b0); step();
    send(6'd6, 6'd4, 1'b0, 1'b0); step();
    send(6'd7, 6'd4, 1'b0, 1'b0); step();
    send(6'd40, 6'd3, 1'b0, 1'b1);
    check("reuse_load",   32'(load), 32'h1);
    check("reuse_stolen", 32'(stolen), 32'h0);
    check("reuse_vdone",  32'(voice_done), 32'h0);
    check("reuse_act",    32'(voice_active), 32'h7);
    check("reuse_vnote",  32'(voice_note), 32'({6'd7, 6'd6, 6'd40}));

    // Pause during WAIT_BEATS
    do_reset();
    send(6'd9, 6'd3, 1'b1, 1'b0);
    beat_after(2);
    play = 1'b0;
    nd_seen = 0;
    for (int k = 0; k < 40; k++) begin
      beat = (k % 10 == 9);
      step();
      beat = 1'b0;
      nd_seen += int'(note_done);
    end
    check("pause_nd",  32'(nd_seen), 32'h0);
    check("pause_act", 32'(voice_active), 32'h1);
    play = 1'b1;
    beat_after(2);
    check("pause_b2_nd", 32'(note_done), 32'h0);
    beat_after(2);
    check("pause_b3_nd",    32'(note_done), 32'h1);
    check("pause_b3_vdone", 32'(voice_done), 32'h1);
    step();

    // Rest with a protocol error injected mid-step
    send(6'd0, 6'd4, 1'b1, 1'b0);
    check("rest_load", 32'(load), 32'h0);
    beat_after(2);
    check("rest_b1_nd", 32'(note_done), 32'h0);
    beat_after(2);
    check("rest_b2_nd", 32'(note_done), 32'h0);
    send(6'd8, 6'd2, 1'b1, 1'b0);
    check("perr_set",  32'(protocol_err), 32'h1);
    check("perr_load", 32'(load), 32'h0);
    beat_after(2);
    check("rest_b3_nd", 32'(note_done), 32'h0);
    beat_after(2);
    check("rest_b4_nd",  32'(note_done), 32'h1);
    check("perr_sticky", 32'(protocol_err), 32'h1);

    // Reset clears everything
    send(6'd11, 6'd6, 1'b1, 1'b0);
    do_reset();
    check("rst2_perr",   32'(protocol_err), 32'h0);
    check("rst2_active", 32'(voice_active), 32'h0);
    check("rst2_vnote",  32'(voice_note), 32'h0);
    step();
    check("rst2_nd", 32'(note_done), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/voice_allocator.md
# voice_allocator

Sequencer between the song reader and three note players. Each note the song reader presents is assigned to a free voice, or to a stolen voice if all are busy. Each voice's remaining length is counted in beats. `note_done` tells the song reader when to fetch the next note, so single notes and chords are both supported.

## Interface

Parameters:
- `NOTE_WIDTH`, 6, note code width; code 0 is a rest.
- `DUR_WIDTH`, 6, duration width in beats.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `play`  in  1  run/pause; low freezes all beat counting.
- `beat`  in  1  one-cycle tick marking one duration unit.
- `new_note`  in  1  one-cycle pulse from the song reader; `note`/`duration`/`advance` are valid in that cycle.
- `note`  in  NOTE_WIDTH  note code.
- `duration`  in  DUR_WIDTH  length in beats.
- `advance`  in  1  1 = the song time step lasts `duration` beats; 0 = chord member, the next note is fetched at once.
- `load`  out  3  one-hot, one-cycle pulse: the voice was just (re)loaded.
- `voice_note`  out  3*NOTE_WIDTH  `{v2,v1,v0}`; note code held per voice, 0 when the voice is idle.
- `voice_active`  out  3  voice currently sounding.
- `voice_done`  out  3  one-cycle pulse when a voice expires naturally.
- `note_done`  out  1  one-cycle pulse to the song reader: the step is complete.
- `stolen`  out  1  one-cycle pulse: an allocation evicted an active voice.
- `protocol_err`  out  1  sticky; set when `new_note` arrives outside IDLE.

## Operation

Voice state, per voice i:
- `active[i]`, `vnote[i]` (NOTE_WIDTH bits), `vcnt[i]` (DUR_WIDTH bits).

Expiry (evaluated first each cycle):
- A voice expires when `beat && play && active[i] && vcnt[i]==1`.
- Next cycle: `active[i]`=0, `vnote[i]`=0, `voice_done[i]`=1.
- Other active voices with `beat && play` decrement `vcnt`.

Allocation, on `new_note` in IDLE:
- Skipped when `note==0` (rest) or `duration==0`; no `load`.
- Free set = voices not active, or expiring this cycle.
- If the free set is non-empty, take its lowest index.
- If it is empty, steal the voice with the smallest `vcnt`, ties to the lowest index. That voice gets no `voice_done`; `stolen` pulses instead.
- The chosen voice gets `active`=1, `vnote`=`note`, `vcnt`=`duration`. It is not decremented in the load cycle, even if `beat` is high.

Step FSM, 2-bit state: IDLE, WAIT_BEATS, DONE.
- IDLE: on `new_note`, if `advance && duration!=0`, go to WAIT_BEATS with `tcnt`=`duration`. Otherwise go to DONE.
- WAIT_BEATS: on `beat && play`, if `tcnt==1` go to DONE, else decrement `tcnt`.
- WAIT_BEATS with `play` low: hold.
- DONE: `note_done`=1 for exactly one cycle, then IDLE.
- `new_note` outside IDLE is ignored and sets `protocol_err`.

Pause behaviour:
- `play` low never clears voices.
- `play` low does not block allocation or the DONE pulse.

Reset values:
- All voices inactive, all counters 0, FSM in IDLE.
- All outputs 0, including `protocol_err`.
- Reset mid-note or mid-steal discards everything; there is no pending `note_done`.

## Timing

- `new_note` sampled at edge t: `load` and `voice_note` update are visible in cycle t+1.
- Chord note or rest (`advance`=0, or `duration`=0): `note_done` high in cycle t+1.
- Timed note: `note_done` high one cycle after the registering edge of the `duration`-th qualifying beat after t.
- A beat in the same cycle as `new_note` does not count toward that note's `tcnt`.
- Expiry: `voice_done` and the `active` drop happen in the cycle after the final beat.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan

- Reset, then single note: `new_note` with note=20, dur=3, adv=1, with `beat` every 10 cycles.
  - `load`=3'b001 and `voice_note[5:0]`=20 at t+1.
  - `note_done` one cycle after the 3rd beat.
  - `voice_done[0]` in the same cycle, then `voice_active`=0.
- Chord: notes 10, 14 with adv=0, then 17 with adv=1, dur=2.
  - `note_done` at t+1 after each of 10 and 14.
  - Voices 0, 1, 2 loaded in order; all three active.
- Steal: three active voices with vcnt 5, 2, 2, then a new note 30.
  - Voice 1 is reloaded with 30; `stolen`=1; no `voice_done[1]`.
- Same-cycle expiry: voice 0 at vcnt=1, `beat` coincides with `new_note`, voices 1 and 2 busy.
  - Voice 0 is reused; `load`=3'b001; no `stolen`.
  - `voice_done[0]` does not fire, because the voice is reloaded.
- Pause: `play` low for 40 cycles in WAIT_BEATS with beats arriving.
  - `tcnt`/`vcnt` frozen; `note_done` is delayed by exactly the paused beats.
- Rest, protocol error, reset:
  - Rest note=0, dur=4, adv=1: no `load`; `note_done` after 4 beats.
  - `new_note` during WAIT_BEATS: `protocol_err`=1 and stays set.
  - Reset clears `protocol_err` and all outputs.
